// File: rtl/a2d_arb_pkg.sv
// Shared types for the A2D arbiter: FSM state encoding, owner encoding and
// the fixed-priority/starvation winner selection.
package a2d_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_MC   = 1'b0,
    OWN_BATT = 1'b1
  } owner_e;

  // Requester 0 wins ties unless requester 1 has been starved out.
  function automatic owner_e pick_owner(logic r0, logic r1, logic starved);
    if (r1 && (!r0 || starved)) return OWN_BATT;
    return OWN_MC;
  endfunction

endpackage

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: shares one A2D converter between the motion controller
// (req0, high priority) and the battery monitor (req1). Fixed priority with a
// starvation guard, plus a watchdog that aborts a conversion whose cnv_cmplt
// never arrives.
//   clk, rst_n            : clock, async active-low reset
//   req0/1, chnnl0/1      : requests and requested channels (sampled at grant)
//   gnt0/1, cmplt0/1, err : owner indication, done pulse, timeout flag
//   res                   : result to owner, valid in DONE and held afterwards
//   strt_cnv, chnnl       : start pulse and channel to the A2D
//   cnv_cmplt, A2D_res    : conversion done pulse and result from the A2D
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  chnnl0,
  input  logic [2:0]  chnnl1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        cmplt0,
  output logic        cmplt1,
  output logic        err,
  output logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned SV_W  = $clog2(STARVE_LIM + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [SV_W-1:0]   starve_q, starve_d;
  logic [2:0]        chnnl_q, chnnl_d;
  logic [11:0]       res_q, res_d;
  logic              strt_q, strt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              cmplt0_q, cmplt0_d;
  logic              cmplt1_q, cmplt1_d;
  logic              err_q, err_d;
  owner_e            win;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    chnnl_d  = chnnl_q;
    res_d    = res_q;
    strt_d   = 1'b0;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    cmplt0_d = 1'b0;
    cmplt1_d = 1'b0;
    err_d    = 1'b0;
    win      = OWN_MC;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win     = pick_owner(req0, req1, starve_q == SV_W'(STARVE_LIM));
          owner_d = win;
          chnnl_d = (win == OWN_BATT) ? chnnl1 : chnnl0;
          if (win == OWN_BATT) begin
            starve_d = '0;
          end else if (req1 && (starve_q != SV_W'(STARVE_LIM))) begin
            starve_d = SV_W'(starve_q + 1'b1);
          end
          strt_d  = 1'b1;
          gnt0_d  = (win == OWN_MC);
          gnt1_d  = (win == OWN_BATT);
          state_d = START;
        end
      end

      START: begin
        tmo_d   = '0;
        state_d = BUSY;
      end

      BUSY: begin
        // A completion on the same edge as the timeout takes precedence.
        if (cnv_cmplt) begin
          res_d    = A2D_res;
          cmplt0_d = (owner_q == OWN_MC);
          cmplt1_d = (owner_q == OWN_BATT);
          state_d  = DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          res_d    = 12'h000;
          err_d    = 1'b1;
          cmplt0_d = (owner_q == OWN_MC);
          cmplt1_d = (owner_q == OWN_BATT);
          state_d  = DONE;
        end else begin
          tmo_d = TMO_W'(tmo_q + 1'b1);
        end
      end

      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_MC;
      tmo_q    <= '0;
      starve_q <= '0;
      chnnl_q  <= 3'b000;
      res_q    <= 12'h000;
      strt_q   <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      cmplt0_q <= 1'b0;
      cmplt1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
      chnnl_q  <= chnnl_d;
      res_q    <= res_d;
      strt_q   <= strt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      cmplt0_q <= cmplt0_d;
      cmplt1_q <= cmplt1_d;
      err_q    <= err_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign cmplt0   = cmplt0_q;
  assign cmplt1   = cmplt1_q;
  assign err      = err_q;
  assign res      = res_q;
  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed self-checking bench for a2d_arbiter.
module tb_a2d_arbiter;

  localparam int unsigned TIMEOUT    = 1024;
  localparam int unsigned STARVE_LIM = 4;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [2:0]  chnnl0, chnnl1;
  logic        gnt0, gnt1, cmplt0, cmplt1, err;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;

  int total = 0;
  int bad   = 0;
  int n_strt = 0;
  int n_cmplt1 = 0;

  a2d_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .chnnl0(chnnl0), .chnnl1(chnnl1),
    .gnt0(gnt0), .gnt1(gnt1), .cmplt0(cmplt0), .cmplt1(cmplt1),
    .err(err), .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (strt_cnv) n_strt++;
    if (cmplt1)   n_cmplt1++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for the START cycle.
  task automatic wait_strt();
    for (int i = 0; i < 10; i++) begin
      if (strt_cnv) break;
      step(1);
    end
    chk("strt_seen", 32'(strt_cnv), 32'd1);
  endtask

  // One full transaction: grant, lat cycles in BUSY, completion, back to IDLE.
  task automatic do_txn(input logic exp_own, input logic [2:0] exp_ch,
                        input logic [11:0] data, input int lat);
    wait_strt();
    chk("grant_owner", 32'(gnt1), 32'(exp_own));
    chk("grant_excl",  32'(gnt0 ^ gnt1), 32'd1);
    chk("grant_chnnl", 32'(chnnl), 32'(exp_ch));
    step(1);
    chk("busy_strt_low", 32'(strt_cnv), 32'd0);
    step(lat - 1);
    cnv_cmplt = 1'b1;
    A2D_res   = data;
    step(1);
    cnv_cmplt = 1'b0;
    chk("done_cmplt_own", 32'(exp_own ? cmplt1 : cmplt0), 32'd1);
    chk("done_cmplt_oth", 32'(exp_own ? cmplt0 : cmplt1), 32'd0);
    chk("done_res", 32'(res), 32'(data));
    chk("done_err", 32'(err), 32'd0);
    step(1);
    chk("idle_cmplt", 32'({cmplt0, cmplt1, gnt0, gnt1}), 32'd0);
  endtask

  initial begin
    logic ord_a [10];
    logic ord_b [5];
    int   strt_base;
    ord_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ord_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; chnnl0 = 3'd0; chnnl1 = 3'd0;
    cnv_cmplt = 1'b0; A2D_res = 12'h000;
    step(2);
    chk("rst_outs", 32'({gnt0, gnt1, cmplt0, cmplt1, err, strt_cnv}), 32'd0);
    chk("rst_res", 32'(res), 32'h000);
    chk("rst_chnnl", 32'(chnnl), 32'd0);
    rst_n = 1'b1;
    step(1);

    // req0 alone, 20-cycle conversion.
    req0 = 1'b1; chnnl0 = 3'd4; chnnl1 = 3'd1;
    do_txn(1'b0, 3'd4, 12'hA5C, 20);
    req0 = 1'b0;
    step(2);
    chk("t1_one_strt", 32'(n_strt), 32'd1);
    chk("t1_no_cmplt1", 32'(n_cmplt1), 32'd0);
    chk("t1_chnnl_hold", 32'(chnnl), 32'd4);
    chk("t1_res_hold", 32'(res), 32'hA5C);

    // Both requesters held: starvation guard forces every fifth grant.
    req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd2; chnnl1 = 3'd6;
    strt_base = n_strt;
    for (int i = 0; i < 10; i++)
      do_txn(ord_a[i], ord_a[i] ? 3'd6 : 3'd2, 12'(12'h100 + i), 3);
    req0 = 1'b0; req1 = 1'b0;
    step(1);
    chk("t2_strt_count", 32'(n_strt - strt_base), 32'd10);

    // req1 alone, A2D never answers: watchdog abort.
    req1 = 1'b1; chnnl1 = 3'd3;
    wait_strt();
    step(1);
    step(TIMEOUT - 1);
    chk("t3_pre_tmo", 32'({cmplt1, err}), 32'd0);
    step(1);
    chk("t3_tmo_cmplt1", 32'(cmplt1), 32'd1);
    chk("t3_tmo_err", 32'(err), 32'd1);
    chk("t3_tmo_res", 32'(res), 32'h000);
    req1 = 1'b0;
    step(1);
    chk("t3_idle", 32'({cmplt1, err, gnt1}), 32'd0);

    // cnv_cmplt on the timeout edge wins.
    req0 = 1'b1; chnnl0 = 3'd5;
    wait_strt();
    step(1);
    step(TIMEOUT - 1);
    chk("t4_pre", 32'(cmplt0), 32'd0);
    cnv_cmplt = 1'b1; A2D_res = 12'h3C7;
    step(1);
    cnv_cmplt = 1'b0;
    chk("t4_cmplt0", 32'(cmplt0), 32'd1);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_res", 32'(res), 32'h3C7);
    req0 = 1'b0;
    step(1);

    // Build up starvation, then reset during BUSY with a result in flight.
    req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd1; chnnl1 = 3'd7;
    for (int i = 0; i < 3; i++) do_txn(1'b0, 3'd1, 12'(12'h200 + i), 2);
    wait_strt();
    step(3);
    cnv_cmplt = 1'b1; A2D_res = 12'hFFF;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 32'({gnt0, gnt1, cmplt0, cmplt1, err, strt_cnv}), 32'd0);
    chk("t5_rst_res", 32'(res), 32'h000);
    chk("t5_rst_chnnl", 32'(chnnl), 32'd0);
    step(2);
    cnv_cmplt = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      do_txn(ord_b[i], ord_b[i] ? 3'd7 : 3'd1, 12'(12'h300 + i), 2);
    req0 = 1'b0; req1 = 1'b0;
    step(1);

    // Spurious cnv_cmplt in IDLE and START.
    cnv_cmplt = 1'b1; A2D_res = 12'h123;
    step(2);
    chk("t6_idle_cmplt", 32'({cmplt0, cmplt1, gnt0, gnt1}), 32'd0);
    chk("t6_idle_res", 32'(res), 32'h304);
    req0 = 1'b1; chnnl0 = 3'd6;
    step(1);
    chk("t6_start", 32'({strt_cnv, gnt0}), 32'd3);
    step(1);
    cnv_cmplt = 1'b0;
    chk("t6_start_ign", 32'({cmplt0, gnt0}), 32'd1);
    step(2);
    chk("t6_busy_hold", 32'({cmplt0, gnt0}), 32'd1);
    cnv_cmplt = 1'b1; A2D_res = 12'h456;
    step(1);
    cnv_cmplt = 1'b0;
    req0 = 1'b0;
    chk("t6_cmplt0", 32'(cmplt0), 32'd1);
    chk("t6_res", 32'(res), 32'h456);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
